// File: rtl/fft_buf_pkg.sv
// fft_buf_pkg: shared one-hot state encodings, Q15 scale and bit-reversal helper
// for the FFT sample buffer and its optional Hann window ROM.
// Optional feature macro used by the consumers: FFT_BUF_WINDOW_EN.
package fft_buf_pkg;

  // One-hot sequencer states (legacy-compatible constants)
  localparam logic [4:0] ST_FILL  = 5'b00001;
  localparam logic [4:0] ST_START = 5'b00010;
  localparam logic [4:0] ST_RUN   = 5'b00100;
  localparam logic [4:0] ST_DRAIN = 5'b01000;
  localparam logic [4:0] ST_ACK   = 5'b10000;

  // Window coefficients are unsigned Q15; product is shifted back by this amount
  localparam int Q15_SHIFT = 15;

  // Reverse the low m bits of x (DIT input ordering)
  function automatic int bitrev(input int x, input int m);
    int r;
    r = 0;
    for (int i = 0; i < m; i++) begin
      r = (r << 1) | ((x >> i) & 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_sample_buffer_if.sv
// fft_sample_buffer_if: sample stream in, bin stream out, and the FFT core
// memory/control port. The buffer takes the master view, the environment
// (source, sink and FFT core) takes the slave view.
interface fft_sample_buffer_if #(
  parameter int M  = 8,
  parameter int DW = 32
);
  // Input sample stream
  logic                 in_valid;
  logic                 in_ready;
  logic signed [15:0]   in_data;

  // Output bin stream
  logic                 out_valid;
  logic                 out_ready;
  logic [M-1:0]         out_index;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;

  // FFT core control and data
  logic                 fft_start;
  logic                 fft_ack;
  logic                 fft_done;
  logic                 fft_proc;
  logic [M-1:0]         fft_i_top;
  logic [M-1:0]         fft_i_bot;
  logic signed [DW-1:0] fft_x_top_re;
  logic signed [DW-1:0] fft_x_top_im;
  logic signed [DW-1:0] fft_x_bot_re;
  logic signed [DW-1:0] fft_x_bot_im;
  logic signed [DW-1:0] fft_y_top_re;
  logic signed [DW-1:0] fft_y_top_im;
  logic signed [DW-1:0] fft_y_bot_re;
  logic signed [DW-1:0] fft_y_bot_im;

  modport master (
    input  in_valid, in_data, out_ready,
    input  fft_done, fft_proc, fft_i_top, fft_i_bot,
    input  fft_y_top_re, fft_y_top_im, fft_y_bot_re, fft_y_bot_im,
    output in_ready, out_valid, out_index, out_re, out_im,
    output fft_start, fft_ack,
    output fft_x_top_re, fft_x_top_im, fft_x_bot_re, fft_x_bot_im
  );

  modport slave (
    output in_valid, in_data, out_ready,
    output fft_done, fft_proc, fft_i_top, fft_i_bot,
    output fft_y_top_re, fft_y_top_im, fft_y_bot_re, fft_y_bot_im,
    input  in_ready, out_valid, out_index, out_re, out_im,
    input  fft_start, fft_ack,
    input  fft_x_top_re, fft_x_top_im, fft_x_bot_re, fft_x_bot_im
  );

endinterface

// File: rtl/fft_buf_window_rom.sv
// fft_buf_window_rom: M-bit sample index to unsigned Q15 Hann coefficient (0..32767).
// Latency: combinational lookup, table built at elaboration.
// Backpressure: none, pure function of the index. Used only with FFT_BUF_WINDOW_EN.
module fft_buf_window_rom
  import fft_buf_pkg::*;
#(
  parameter int N = 256,
  parameter int M = 8
) (
  input  logic [M-1:0] i_idx,
  output logic [15:0]  o_coef
);

  // w[n] = 0.5*(1 - cos(2*pi*n/N)) at full Q15 scale, rounded to nearest
  function automatic logic [N*16-1:0] build_hann();
    logic [N*16-1:0] t;
    real             ph;
    int              v;
    t = '0;
    for (int n = 0; n < N; n++) begin
      ph = 2.0 * 3.14159265358979323846 * real'(n) / real'(N);
      v  = $rtoi(0.5 * (1.0 - $cos(ph)) * real'((1 << Q15_SHIFT) - 1) + 0.5);
      t[n*16 +: 16] = 16'(v);
    end
    return t;
  endfunction

  localparam logic [N*16-1:0] HANN = build_hann();

  assign o_coef = HANN[{i_idx, 4'b0000} +: 16];

endmodule

// File: rtl/fft_sample_buffer.sv
// fft_sample_buffer: in-place working memory and sequencer around a radix-2 DIT FFT core.
// Latency: N fill cycles, one start cycle, core run until Done, then N bins in natural order.
// Backpressure: in_ready only in FILL; bins held stable while out_ready low. Option: FFT_BUF_WINDOW_EN.
module fft_sample_buffer
  import fft_buf_pkg::*;
#(
  parameter int N  = 256,
  parameter int M  = 8,
  parameter int DW = 32
) (
  input  logic Clk,
  input  logic Reset,
  fft_sample_buffer_if.master bus
);

  logic [4:0]           r_state;
  logic [M-1:0]         r_cnt;
  logic                 r_live;
  logic signed [DW-1:0] r_mem_re [N];
  logic signed [DW-1:0] r_mem_im [N];

  logic                 w_is_fill;
  logic                 w_is_drain;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_proc_wr;
  logic                 w_cnt_last;
  logic [M-1:0]         w_fill_addr;
  logic signed [DW-1:0] w_fill_dat;

  assign w_is_fill   = (r_state == ST_FILL);
  assign w_is_drain  = (r_state == ST_DRAIN);
  assign w_cnt_last  = (r_cnt == M'(N - 1));
  assign w_fill_addr = M'(bitrev(32'(r_cnt), M));

  // r_live keeps in_ready low while Reset is held, even though the state is FILL
  assign bus.in_ready = w_is_fill & r_live;
  assign w_in_fire    = bus.in_valid & bus.in_ready;
  assign w_out_fire   = w_is_drain & bus.out_ready;
  assign w_proc_wr    = (r_state == ST_RUN) & bus.fft_proc;

`ifdef FFT_BUF_WINDOW_EN
  logic [15:0]         w_coef;
  logic signed [32:0]  w_prod;

  // Coefficient follows arrival order, storage address is bit-reversed
  fft_buf_window_rom #(
    .N (N),
    .M (M)
  ) u_window_rom (
    .i_idx  (r_cnt),
    .o_coef (w_coef)
  );

  assign w_prod     = 33'($signed(bus.in_data)) * 33'($signed({1'b0, w_coef}));
  assign w_fill_dat = DW'(w_prod >>> Q15_SHIFT);
`else
  assign w_fill_dat = DW'(bus.in_data);
`endif

  // Output stream: bin cnt straight from memory, zeroed outside DRAIN
  assign bus.out_valid = w_is_drain;
  assign bus.out_index = w_is_drain ? r_cnt : '0;
  assign bus.out_re    = w_is_drain ? r_mem_re[r_cnt] : '0;
  assign bus.out_im    = w_is_drain ? r_mem_im[r_cnt] : '0;

  // Core strobes are one-cycle states
  assign bus.fft_start = (r_state == ST_START);
  assign bus.fft_ack   = (r_state == ST_ACK);

  // Core read ports are asynchronous and live in every state
  assign bus.fft_x_top_re = r_mem_re[bus.fft_i_top];
  assign bus.fft_x_top_im = r_mem_im[bus.fft_i_top];
  assign bus.fft_x_bot_re = r_mem_re[bus.fft_i_bot];
  assign bus.fft_x_bot_im = r_mem_im[bus.fft_i_bot];

  // Sequencer: FILL -> START -> RUN -> DRAIN -> ACK -> FILL
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_FILL;
      r_cnt   <= '0;
      r_live  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        ST_FILL: begin
          if (w_in_fire) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_cnt_last) begin
              r_state <= ST_START;
            end
          end
        end
        ST_START: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.fft_done) begin
            r_state <= ST_DRAIN;
            r_cnt   <= '0;
          end
        end
        ST_DRAIN: begin
          if (w_out_fire) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_cnt_last) begin
              r_state <= ST_ACK;
            end
          end
        end
        ST_ACK: begin
          r_state <= ST_FILL;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= ST_FILL;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Working memory: sample writes in FILL, in-place butterfly writes while the core is in PROC
  always_ff @(posedge Clk) begin
    if (w_in_fire) begin
      r_mem_re[w_fill_addr] <= w_fill_dat;
      r_mem_im[w_fill_addr] <= '0;
    end
    if (w_proc_wr) begin
      r_mem_re[bus.fft_i_top] <= bus.fft_y_top_re;
      r_mem_im[bus.fft_i_top] <= bus.fft_y_top_im;
      r_mem_re[bus.fft_i_bot] <= bus.fft_y_bot_re;
      r_mem_im[bus.fft_i_bot] <= bus.fft_y_bot_im;
    end
  end

endmodule

// File: tb/tb_fft_sample_buffer.sv
// tb_fft_sample_buffer: drives frames into fft_sample_buffer, emulates the FFT core
// (full radix-2 butterflies or a Done-only stub) and checks every output bin
// against a DFT / bit-reversal reference. Build with FFT_BUF_WINDOW_EN for the Hann case.
module tb_fft_sample_buffer;

  localparam int  N  = 256;
  localparam int  M  = 8;
  localparam int  DW = 32;
  localparam real PI = 3.14159265358979323846;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  always #5 Clk = ~Clk;

  fft_sample_buffer_if #(.M(M), .DW(DW)) bus ();

  fft_sample_buffer #(.N(N), .M(M), .DW(DW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.master)
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  longint frame  [N];
  longint stored [N];
  longint exp_re [N];
  longint exp_im [N];
  longint got_re [N];
  longint got_im [N];
  longint tol          = 1;
  int     exp_idx      = 0;
  int     drain_cycles = 0;
  bit     cmp_en       = 1'b0;
  bit     core_stub    = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input longint act, input longint exp, input longint t);
    n_tests++;
    if (act > exp + t || act < exp - t) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, t);
    end
  endtask

  function automatic int bitrev_m(input int k);
    int r;
    int v;
    r = 0;
    v = k;
    for (int i = 0; i < M; i++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  function automatic longint rnd(input real r);
    if (r >= 0.0) return longint'($rtoi(r + 0.5));
    return -longint'($rtoi(-r + 0.5));
  endfunction

`ifdef FFT_BUF_WINDOW_EN
  function automatic longint hann_m(input int n);
    real s;
    s = $sin(PI * real'(n) / real'(N));
    return rnd(32767.0 * s * s);
  endfunction
`endif

  // Reference: stored samples, then either the plain DFT or the bit-reversed memory image
  task automatic build_model();
    real sr;
    real si;
    real ang;
    for (int n = 0; n < N; n++) begin
`ifdef FFT_BUF_WINDOW_EN
      stored[n] = (frame[n] * hann_m(n)) >>> 15;
`else
      stored[n] = frame[n];
`endif
    end
    for (int k = 0; k < N; k++) begin
      if (core_stub) begin
        exp_re[k] = stored[bitrev_m(k)];
        exp_im[k] = 0;
      end else begin
        sr = 0.0;
        si = 0.0;
        for (int n = 0; n < N; n++) begin
          if (stored[n] != 0) begin
            ang = 2.0 * PI * real'((k * n) % N) / real'(N);
            sr  = sr + real'(stored[n]) * $cos(ang);
            si  = si - real'(stored[n]) * $sin(ang);
          end
        end
        exp_re[k] = rnd(sr);
        exp_im[k] = rnd(si);
      end
    end
  endtask

  // FFT core emulation: one butterfly per cycle, or Done two cycles after Start
  task automatic core_run();
    longint xtr, xti, xbr, xbi, tr, ti;
    real    ang, wr, wi;
    int     len, half, guard;
    if (core_stub) begin
      @(posedge Clk); #1;
      if (Reset) return;
      @(posedge Clk); #1;
      if (Reset) return;
    end else begin
      for (int s = 1; s <= M; s++) begin
        len  = 1 << s;
        half = len / 2;
        for (int g = 0; g < N; g += len) begin
          for (int j = 0; j < half; j++) begin
            @(posedge Clk); #1;
            if (Reset) begin
              bus.fft_proc = 1'b0;
              return;
            end
            bus.fft_proc  = 1'b1;
            bus.fft_i_top = M'(g + j);
            bus.fft_i_bot = M'(g + j + half);
            #1;
            xtr = longint'(bus.fft_x_top_re);
            xti = longint'(bus.fft_x_top_im);
            xbr = longint'(bus.fft_x_bot_re);
            xbi = longint'(bus.fft_x_bot_im);
            ang = 2.0 * PI * real'(j) / real'(len);
            wr  = $cos(ang);
            wi  = -$sin(ang);
            tr  = rnd(real'(xbr) * wr - real'(xbi) * wi);
            ti  = rnd(real'(xbr) * wi + real'(xbi) * wr);
            bus.fft_y_top_re = DW'(xtr + tr);
            bus.fft_y_top_im = DW'(xti + ti);
            bus.fft_y_bot_re = DW'(xtr - tr);
            bus.fft_y_bot_im = DW'(xti - ti);
          end
        end
      end
      @(posedge Clk); #1;
      bus.fft_proc = 1'b0;
      if (Reset) return;
    end
    bus.fft_done = 1'b1;
    guard = 0;
    while (guard < 4000) begin
      @(negedge Clk);
      guard++;
      if (Reset) break;
      if (bus.fft_ack) begin
        @(posedge Clk); #1;
        break;
      end
    end
    bus.fft_done = 1'b0;
  endtask

  initial begin
    bus.fft_done     = 1'b0;
    bus.fft_proc     = 1'b0;
    bus.fft_i_top    = '0;
    bus.fft_i_bot    = '0;
    bus.fft_y_top_re = '0;
    bus.fft_y_top_im = '0;
    bus.fft_y_bot_re = '0;
    bus.fft_y_bot_im = '0;
    forever begin
      @(negedge Clk);
      if (!Reset && bus.fft_start) core_run();
    end
  end

  // Compare process: every valid bin must be the next index with the reference value
  always @(negedge Clk) begin
    if (!Reset && bus.out_valid) begin
      drain_cycles++;
      if (exp_idx < N) begin
        if (cmp_en) begin
          check("out_index", longint'(bus.out_index), longint'(exp_idx));
          check_tol("out_re", longint'(bus.out_re), exp_re[exp_idx], tol);
          check_tol("out_im", longint'(bus.out_im), exp_im[exp_idx], tol);
        end
        got_re[exp_idx] = longint'(bus.out_re);
        got_im[exp_idx] = longint'(bus.out_im);
      end else begin
        n_tests++;
        n_fail++;
        $display("FAIL bin_overrun: got bin beyond %0d, expected ack", exp_idx);
      end
      if (bus.out_ready) exp_idx++;
    end
  end

  task automatic apply_reset();
    Reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_in_ready",  longint'(bus.in_ready), 0);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_out_index", longint'(bus.out_index), 0);
    check("rst_out_re",    longint'(bus.out_re), 0);
    check("rst_out_im",    longint'(bus.out_im), 0);
    check("rst_fft_start", longint'(bus.fft_start), 0);
    check("rst_fft_ack",   longint'(bus.fft_ack), 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    @(negedge Clk);
    check("post_rst_in_ready", longint'(bus.in_ready), 1);
  endtask

  task automatic send_frame();
    int n;
    int guard;
    bit acc;
    n     = 0;
    guard = 0;
    @(posedge Clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'(frame[0]);
    while (n < N && guard < 4 * N) begin
      @(negedge Clk);
      guard++;
      acc = bus.in_ready;
      @(posedge Clk); #1;
      if (acc) begin
        n++;
        if (n < N) bus.in_data = 16'(frame[n]);
      end
    end
    bus.in_valid = 1'b0;
    check("fill_count", longint'(n), N);
    check("fill_cycles", longint'(guard), N);
    @(negedge Clk);
    check("start_hi", longint'(bus.fft_start), 1);
    check("in_ready_start", longint'(bus.in_ready), 0);
`ifdef FFT_BUF_WINDOW_EN
    check("win_mem0", longint'(dut.r_mem_re[0]), 0);
`endif
    @(negedge Clk);
    check("start_lo", longint'(bus.fft_start), 0);
    check("in_ready_run", longint'(bus.in_ready), 0);
  endtask

  task automatic run_frame(input bit bp);
    int guard;
    exp_idx      = 0;
    drain_cycles = 0;
    build_model();
    cmp_en        = 1'b1;
    bus.out_ready = 1'b1;
    send_frame();
    guard = 0;
    while (exp_idx < N && guard < 4000) begin
      @(posedge Clk); #1;
      guard++;
      if (bp && bus.out_valid) bus.out_ready = ~bus.out_ready;
    end
    check("drain_bins", longint'(exp_idx), N);
    check("drain_cycles", longint'(drain_cycles), bp ? 2 * N : N);
    @(negedge Clk);
    check("ack_hi", longint'(bus.fft_ack), 1);
    check("ack_out_valid", longint'(bus.out_valid), 0);
    @(negedge Clk);
    check("ack_lo", longint'(bus.fft_ack), 0);
    check("refill_in_ready", longint'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    int guard;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
`ifdef FFT_BUF_WINDOW_EN
    tol = 16;
`endif
    apply_reset();

    check("model_bitrev_1", longint'(bitrev_m(1)), 128);
    check("model_bitrev_9", longint'(bitrev_m(9)), 144);

    // Impulse through the full butterfly core
    core_stub = 1'b0;
    for (int n = 0; n < N; n++) frame[n] = 0;
    frame[0] = 1000;
    run_frame(1'b0);
`ifndef FFT_BUF_WINDOW_EN
    check("model_impulse_200", exp_re[200], 1000);
    check("impulse_bin255_re", got_re[255], 1000);
`endif

    // DC through the full butterfly core
    for (int n = 0; n < N; n++) frame[n] = 100;
    run_frame(1'b0);
`ifndef FFT_BUF_WINDOW_EN
    check("model_dc_bin0", exp_re[0], 25600);
    check("dc_bin0_re", got_re[0], 25600);
    check_tol("dc_bin7_re", got_re[7], 0, 1);
`endif

    // Bit-reversed storage visible through a Done-only core
    core_stub = 1'b1;
    for (int n = 0; n < N; n++) frame[n] = n;
    run_frame(1'b0);
`ifndef FFT_BUF_WINDOW_EN
    check("bitrev_idx1", got_re[1], 128);
    check("bitrev_idx9", got_re[9], 144);
`endif

    // Output backpressure, ready toggling every drain cycle
    for (int n = 0; n < N; n++) frame[n] = n * 7 - 500;
    run_frame(1'b1);

    // Reset in the middle of DRAIN, then a fresh frame
    for (int n = 0; n < N; n++) frame[n] = 300 - n * 3;
    exp_idx      = 0;
    drain_cycles = 0;
    build_model();
    cmp_en = 1'b1;
    send_frame();
    guard = 0;
    while (exp_idx < 37 && guard < 2000) begin
      @(posedge Clk); #1;
      guard++;
    end
    check("mid_drain_bin", longint'(exp_idx), 37);
    Reset  = 1'b1;
    cmp_en = 1'b0;
    @(negedge Clk);
    check("mid_rst_out_valid", longint'(bus.out_valid), 0);
    check("mid_rst_in_ready", longint'(bus.in_ready), 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    @(negedge Clk);
    check("after_rst_in_ready", longint'(bus.in_ready), 1);
    check("after_rst_out_valid", longint'(bus.out_valid), 0);
    for (int n = 0; n < N; n++) frame[n] = n * 11 - 1400;
    run_frame(1'b0);

`ifdef FFT_BUF_WINDOW_EN
    // Hann-windowed full-scale DC: bin 0 near 32767*N/2
    core_stub = 1'b0;
    for (int n = 0; n < N; n++) frame[n] = 32767;
    run_frame(1'b0);
    check_tol("win_dc_bin0", got_re[0], 32767 * 128, (32767 * 128 * 5) / 1000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got no completion by time limit, expected summary");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fft_sample_buffer.md
Name: fft_sample_buffer

Overview:
- In-place working memory and sequencer sitting directly upstream and downstream of the radix-2 DIT FFT core.
- Accepts N real 16-bit samples over a valid/ready stream and stores each at its bit-reversed address.
- Issues Start to the core, then serves the core's two combinational read ports and writes the butterfly results back in place each PROC cycle.
- After Done, streams the N complex bins out in natural order, then pulses Ack so the core returns to INIT.

Parameters:
- N, 256, transform length (power of two; must match the FFT core).
- M, 8, log2(N); address width.
- DW, 32, signed word width of each re/im memory entry.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input sample valid.
- in_ready  output  1  buffer can accept a sample.
- in_data  input  16  signed real sample, -32767..32767.
- out_valid  output  1  output bin valid.
- out_ready  input  1  downstream accepts bin.
- out_index  output  M  bin number 0..N-1.
- out_re  output  DW  bin real part.
- out_im  output  DW  bin imaginary part.
- fft_start  output  1  Start to the core.
- fft_ack  output  1  Ack to the core.
- fft_done  input  1  core Done.
- fft_proc  input  1  core PROC state bit (state[1]).
- fft_i_top  input  M  core top index.
- fft_i_bot  input  M  core bottom index.
- fft_x_top_re, fft_x_top_im, fft_x_bot_re, fft_x_bot_im  output  DW each  memory read data to the core.
- fft_y_top_re, fft_y_top_im, fft_y_bot_re, fft_y_bot_im  input  DW each  butterfly results from the core.

Behaviour:
- Clock and reset: single clock Clk; Reset is asynchronous and active-high.
- Storage: two N x DW register arrays, mem_re and mem_im.
  - Reads are asynchronous: fft_x_top_* = mem[fft_i_top] and fft_x_bot_* = mem[fft_i_bot], valid in every state.
- States are FILL, START, RUN, DRAIN, ACK, one-hot. Reset enters FILL with cnt=0.
- Reset values: in_ready=0 during reset and 1 on the first cycle after it; out_valid=0; out_index=0; out_re/out_im=0; fft_start=0; fft_ack=0. Memory is not cleared.
- FILL:
  - in_ready=1.
  - On in_valid&in_ready: mem_re[bitrev(cnt)] <= sign-extended in_data (or windowed, see Optional Feature); mem_im[bitrev(cnt)] <= 0; cnt <= cnt+1.
  - Acceptance of sample cnt==N-1 sends the FSM to START and wraps cnt to 0.
  - fft_done is ignored in FILL.
- START: fft_start=1 for exactly one cycle, then RUN. in_ready=0 from START until the next FILL.
- RUN:
  - On every cycle with fft_proc=1: mem[fft_i_top] <= fft_y_top_* and mem[fft_i_bot] <= fft_y_bot_* at the same edge. The two indices never collide; no other writes occur.
  - fft_done=1 sends the FSM to DRAIN with cnt=0.
  - No timeout; the FSM stays in RUN until Done.
- DRAIN:
  - out_valid=1, out_index=cnt, out_re/out_im=mem[cnt] (combinational from cnt).
  - On out_valid&out_ready: cnt <= cnt+1. Data and index stay stable while out_ready=0.
  - The handshake on cnt==N-1 sends the FSM to ACK.
  - Ready is sampled only in DRAIN; out_valid never depends on out_ready.
- ACK: fft_ack=1 for one cycle, then FILL with cnt=0. The core leaves DONE on that edge.
- Latency: first input to first output = N fill cycles + 2 + (M*N/2 core cycles) + 1; throughput is one sample or bin per cycle with no stalls.
- Reset mid-operation: every state returns immediately to FILL, cnt=0, strobes low. The core is reset by the same Reset.
- bitrev(x) reverses the M address bits: for M=8, bitrev(1)=128 and bitrev(9)=144.

Optional Feature:
- Macro FFT_BUF_WINDOW_EN.
- Defined: in FILL each sample is multiplied by Hann coefficient w[cnt] (Q15, 0..32767) before storage, stored value = (in_data*w[cnt])>>>15. The multiply is combinational, so input timing is unchanged.
- Undefined: the sample is stored sign-extended and unmodified, and no ROM is instantiated.

Decomposition:
- Package fft_buf_pkg holds the state one-hot localparams, the bitrev function (parameterised on M), and Q15 scale constant 15.
- One sub-module: fft_buf_window_rom, a combinational M-bit index to 16-bit Hann coefficient. It is instantiated only under FFT_BUF_WINDOW_EN.

Test Plan:
- Impulse: in_data[0]=1000, rest 0, real core, out_ready=1 → 256 bins with out_re=1000, out_im=0, out_index 0..255 in order, then one-cycle fft_ack.
- DC: all samples 100 → bin0 re=25600, all other bins re=im=0 (±1 LSB), fft_start high exactly 1 cycle after the 256th accept.
- Bit-reversal, with a stub core asserting fft_done two cycles after start and fft_proc=0: input sample n=n → out_re at index k equals bitrev(k) (index 1 →128, 9→144).
- Backpressure: toggle out_ready 1/0 every cycle in DRAIN → out_index/out_re held while low, 256 bins delivered in exactly 512 cycles, no duplicates.
- Reset mid-DRAIN at bin 37 → next cycle in_ready=1, out_valid=0, a fresh 256-sample frame produces a correct result.
- With FFT_BUF_WINDOW_EN, DC 32767 → stored mem_re[0]=0 (w[0]=0) and bin0 re ≈ 32767*256/2 within 0.5%.
